// File: rtl/torus_vc_credit_arb.sv
// Output-link scheduler: round-robin arbitration between requesters, gated by per-VC downstream credits.
// Optional TORUS_CREDIT_CHECK_EN adds a sticky err output for credit overflow and malformed VC requests.
module torus_vc_credit_arb #(
    parameter int N_REQ   = 2,
    parameter int VC_W    = 3,
    parameter int CREDITS = 4,
    parameter int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*VC_W-1:0]   req_vc,
    output logic [N_REQ-1:0]        gnt,
    output logic                    out_v,
    output logic [VC_W-1:0]         out_vc,
    input  logic [VC_W-1:0]         credit_gnt,
    output logic [VC_W-1:0]         credit_avail,
    output logic                    done
`ifdef TORUS_CREDIT_CHECK_EN
    ,
    output logic                    err
`endif
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [CNT_W-1:0] cnt [VC_W];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] next_ptr;
    logic [N_REQ-1:0] slice_ok;
    logic [N_REQ-1:0] eligible;
    logic [VC_W-1:0]  gnt_vc;
    logic [VC_W-1:0]  cnt_full;
    logic             found;
    int               idx;

    genvar gv;
    generate
        for (gv = 0; gv < VC_W; gv++) begin : g_vc
            assign credit_avail[gv] = (cnt[gv] != '0);
            assign cnt_full[gv]     = (cnt[gv] == CNT_W'(CREDITS));
        end
        for (gv = 0; gv < N_REQ; gv++) begin : g_req
            // A slice is legal only if exactly one bit is set; zero is rejected too.
            assign slice_ok[gv] = (req_vc[gv*VC_W +: VC_W] != '0) &&
                                  ((req_vc[gv*VC_W +: VC_W] &
                                    (req_vc[gv*VC_W +: VC_W] - VC_W'(1))) == '0);
            assign eligible[gv] = req[gv] && slice_ok[gv] &&
                                  (|(req_vc[gv*VC_W +: VC_W] & credit_avail));
        end
    endgenerate

    always_comb begin
        gnt      = '0;
        gnt_vc   = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && eligible[idx]) begin
                found       = 1'b1;
                gnt[idx]    = 1'b1;
                gnt_vc      = req_vc[idx*VC_W +: VC_W];
                next_ptr    = PTR_W'((idx + 1) % N_REQ);
            end
        end
        if (rst) begin
            gnt    = '0;
            gnt_vc = '0;
        end
    end

    // A grant and a credit return on the same VC cancel out; returns to a full counter saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VC_W; v++) begin
                cnt[v] <= CNT_W'(CREDITS);
            end
            ptr    <= '0;
            out_v  <= 1'b0;
            out_vc <= '0;
        end else begin
            out_v  <= |gnt;
            out_vc <= gnt_vc;
            if (|gnt) begin
                ptr <= next_ptr;
            end
            for (int v = 0; v < VC_W; v++) begin
                if (gnt_vc[v] && !credit_gnt[v]) begin
                    cnt[v] <= cnt[v] - CNT_W'(1);
                end else if (!gnt_vc[v] && credit_gnt[v] && !cnt_full[v]) begin
                    cnt[v] <= cnt[v] + CNT_W'(1);
                end
            end
        end
    end

    assign done = (&cnt_full) && !(|req) && !out_v;

`ifdef TORUS_CREDIT_CHECK_EN
    logic overflow;
    logic illegal;

    assign overflow = |(credit_gnt & ~gnt_vc & cnt_full);
    assign illegal  = |(req & ~slice_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (overflow || illegal) begin
            err <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(overflow || illegal))
                else $error("torus_vc_credit_arb: credit overflow or malformed req_vc");
        end
    end
`endif
`endif

endmodule

// File: doc/torus_vc_credit_arb.md
Name: torus_vc_credit_arb

Overview:
- Output-link scheduler for one torus switch port (east link or south/PE port).
- Shares a single link between N_REQ requesters, for example client injection and west pass-through traffic.
- Uses round-robin arbitration gated by per-VC credit availability.
- Tracks downstream buffer credits per virtual channel, using vc_target and vc_credit_gnt semantics. Drives the registered link valid and one-hot VC target into the low-swing transmitter.

Parameters:
- N_REQ, 2, number of requesters sharing the link.
- VC_W, 3, number of virtual channels; VC select and credit vectors are one-hot, VC_W bits wide.
- CREDITS, 4, downstream buffer depth per VC (credits at reset); must be at least 1.
- CNT_W, $clog2(CREDITS+1), credit counter width (derived).

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- req  input  N_REQ  per-requester request; held high until granted.
- req_vc  input  N_REQ*VC_W  one-hot target VC per requester; requester i uses bits [i*VC_W +: VC_W].
- gnt  output  N_REQ  one-hot grant (combinational), at most one bit high.
- out_v  output  1  registered link valid.
- out_vc  output  VC_W  registered one-hot VC target of the granted packet.
- credit_gnt  input  VC_W  per-VC credit-return pulses from downstream, one credit per high bit per cycle.
- credit_avail  output  VC_W  bit v high when credit counter v > 0 (registered state).
- done  output  1  all counters equal CREDITS, no req high, out_v low.

Interface (Already decided): one clock; reset is synchronous and active-high — clock port clk, reset port rst.

Behaviour:
- Reset (rst high at a clk edge): all counters = CREDITS, rr pointer = 0, out_v = 0, out_vc = 0.
  - gnt is forced to 0 while rst is high.
  - Reset mid-operation discards in-flight counts; downstream is assumed reset together.
- Eligibility: requester i is eligible iff req[i], req_vc slice i is exactly one-hot, and cnt[that VC] > 0.
  - A non-one-hot slice, including all zeros, is never granted.
- Arbitration (combinational, same cycle):
  - Search from index ptr upward, wrapping modulo N_REQ.
  - Grant the first eligible requester; no eligible requester means gnt = 0.
- Pointer update: on a grant to i, ptr <= (i+1) mod N_REQ at the next edge; with no grant, ptr holds.
- Link output (one-cycle latency):
  - out_v <= |gnt; out_vc <= VC of the granted requester, or 0 when there is no grant.
  - The requester drops or advances req on the cycle after gnt; data is registered by the switch in parallel.
- Credit counters, per VC v: cnt[v] <= cnt[v] - dec[v] + inc[v].
  - dec[v] = grant issued on VC v this cycle.
  - inc[v] = credit_gnt[v].
  - Simultaneous dec and inc on the same VC: counter unchanged.
  - Counter at 0: no grant on that VC, so no underflow.
  - inc at CREDITS with no dec: saturate at CREDITS (overflow; see optional feature).
- Credit timing:
  - A credit returned at cycle t is usable for a grant at cycle t+1.
  - A grant at cycle t that takes the last credit blocks that VC from cycle t+1.
- Throughput: one grant per cycle maximum; back-to-back grants to different requesters are allowed.
- done is combinational from registered state and req.

Optional Feature:
- Macro: TORUS_CREDIT_CHECK_EN.
- When defined: adds output err (1 bit), a sticky register cleared only by rst. It is set on:
  - credit overflow (inc while cnt == CREDITS and no dec), or
  - req[i] high with a non-one-hot req_vc slice.
- When defined, a simulation-only assertion also fires on the same conditions.
- When undefined: no err port, no assertion; overflow silently saturates and illegal requests are silently ignored.

Test Plan:
1. Reset then idle, N_REQ=2, VC_W=3, CREDITS=4 -> credit_avail=3'b111, done=1, out_v=0, gnt=0.
2. req=2'b11, both on VC 3'b001, held high for 6 cycles -> grants alternate 01, 10, 01, 10; stall after 4 grants; credit_avail[0]=0; out_v high for cycles 2-5 with out_vc=3'b001.
3. VC0 exhausted; pulse credit_gnt=3'b001 at cycle t -> exactly one grant on VC0 at t+1, then stall again.
4. cnt[1]=1, grant on VC1 and credit_gnt[1] in the same cycle -> cnt[1] stays 1; a further grant is allowed next cycle.
5. Requester 0 on exhausted VC0, requester 1 on VC2 with credits -> gnt=2'b10 every cycle; requester 0 is not granted until a VC0 credit returns.
6. req_vc slice = 3'b011 with TORUS_CREDIT_CHECK_EN defined -> never granted, err=1 next cycle, err stays 1 until rst; a credit overflow pulse likewise sets err.
